// File: rtl/flag_seq_checker.sv
// flag_seq_checker: streaming front/back end around the per-byte transform
// stage. Accepts candidate bytes, feeds each one plus a position-derived op
// select to the transform, compares the result with the expected-byte ROM
// and reports a held pass/fail verdict with first-mismatch index.
module flag_seq_checker #(
   parameter int FLAG_LEN   = 16,
   parameter int SEL_OFFSET = 0,
   parameter int IDX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic [7:0]       mag_inp,
   output logic [1:0]       mag_val,
   input  logic [7:0]       mag_res,
   output logic [IDX_W-1:0] exp_addr,
   input  logic [7:0]       exp_data,
   output logic             done,
   output logic             pass,
   output logic             len_err,
   output logic             mism,
   output logic [IDX_W-1:0] fail_idx,
   output logic [IDX_W-1:0] byte_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] FLAG_LEN_W = IDX_W'(FLAG_LEN);
   localparam logic [IDX_W-1:0] CNT_MAX    = {IDX_W{1'b1}};
   localparam logic [1:0]       SEL_OFF_W  = 2'(SEL_OFFSET);

   state_t state_q, state_d;

   // stage 1: byte presented to the transform stage
   logic [7:0]       mag_inp_q;
   logic [1:0]       mag_val_q;
   logic [IDX_W-1:0] exp_addr_q;
   logic             s1_valid_q;
   logic             s1_last_q;
   logic [IDX_W-1:0] byte_cnt_q;

   // stage 2: verdict flags
   logic             done_q, pass_q, len_err_q, mism_q;
   logic [IDX_W-1:0] fail_idx_q;

   logic             mism_d, len_err_d, pass_d;
   logic [IDX_W-1:0] fail_idx_d;

   logic             accept;
   logic             finish;
   logic             cmp_mis;

   assign accept = in_valid & in_ready;
   // the stage-1 entry carrying last is compared this cycle and ends the run
   assign finish = s1_valid_q & s1_last_q;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; restart wins over everything
   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (finish) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // output logic: accept bytes unless a verdict is held or restart is pulsed
   always_comb begin
      in_ready = (state_q != S_DONE) & ~restart;
   end

   // stage 1: register the accepted byte, its op select and ROM address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag_inp_q  <= '0;
         mag_val_q  <= '0;
         exp_addr_q <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         byte_cnt_q <= '0;
      end else if (restart) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         // a byte arriving in the same cycle the last one is judged is dropped
         s1_valid_q <= accept & ~finish;
         if (accept & ~finish) begin
            mag_inp_q  <= in_data;
            mag_val_q  <= byte_cnt_q[1:0] + SEL_OFF_W;
            exp_addr_q <= byte_cnt_q;
            s1_last_q  <= in_last;
            if (byte_cnt_q != CNT_MAX) begin
               byte_cnt_q <= byte_cnt_q + 1'b1;
            end
         end
      end
   end

   // stage 2 next-state: compare in-range entries, track first mismatch
   always_comb begin
      cmp_mis    = s1_valid_q & (exp_addr_q < FLAG_LEN_W) & (mag_res != exp_data);
      mism_d     = mism_q | cmp_mis;
      fail_idx_d = fail_idx_q;
      if (cmp_mis & ~mism_q) begin
         fail_idx_d = exp_addr_q;
      end
      len_err_d  = (byte_cnt_q != FLAG_LEN_W);
      pass_d     = ~mism_d & ~len_err_d;
   end

   // stage 2 registers: verdict flags, held until restart
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         len_err_q  <= 1'b0;
         mism_q     <= 1'b0;
         fail_idx_q <= '0;
      end else if (restart) begin
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         len_err_q  <= 1'b0;
         mism_q     <= 1'b0;
         fail_idx_q <= '0;
      end else if (s1_valid_q) begin
         mism_q     <= mism_d;
         fail_idx_q <= fail_idx_d;
         if (s1_last_q) begin
            done_q    <= 1'b1;
            len_err_q <= len_err_d;
            pass_q    <= pass_d;
         end
      end
   end

   assign mag_inp  = mag_inp_q;
   assign mag_val  = mag_val_q;
   assign exp_addr = exp_addr_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign len_err  = len_err_q;
   assign mism     = mism_q;
   assign fail_idx = fail_idx_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_flag_seq_checker.sv
// Directed bench for flag_seq_checker with a behavioural transform stage
// and a 4-entry expected-byte ROM.
module tb_flag_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       restart = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] mag_inp;
   logic [1:0] mag_val;
   logic [7:0] mag_res;
   logic [7:0] exp_addr;
   logic [7:0] exp_data;
   logic       done, pass, len_err, mism;
   logic [7:0] fail_idx, byte_cnt;

   // second instance with SEL_OFFSET=2
   logic       in_valid2 = 1'b0;
   logic [7:0] in_data2 = 8'h00;
   logic       in_ready2;
   logic [7:0] mag_inp2;
   logic [1:0] mag_val2;
   logic [7:0] mag_res2;
   logic [7:0] exp_addr2;
   logic [7:0] exp_data2;
   logic       done2, pass2, len_err2, mism2;
   logic [7:0] fail_idx2, byte_cnt2;

   int n_asserts = 0;
   int n_fail    = 0;
   logic [7:0] cand_b [8];

   always #5 clk = ~clk;

   function automatic logic [7:0] magic(input logic [7:0] b, input logic [1:0] sel);
      case (sel)
         2'd0:    magic = {b[4:0], b[7:5]};
         2'd1:    magic = b ^ 8'h09;
         2'd2:    magic = b + 8'h4D;
         default: magic = b ^ 8'h33;
      endcase
   endfunction

   function automatic logic [7:0] rom(input logic [7:0] a);
      case (a)
         8'd0:    rom = 8'h0A;
         8'd1:    rom = 8'h4A;
         8'd2:    rom = 8'h9B;
         8'd3:    rom = 8'h48;
         default: rom = 8'h00;
      endcase
   endfunction

   assign mag_res   = magic(mag_inp, mag_val);
   assign exp_data  = rom(exp_addr);
   assign mag_res2  = magic(mag_inp2, mag_val2);
   assign exp_data2 = rom(exp_addr2);

   flag_seq_checker #(.FLAG_LEN(4), .SEL_OFFSET(0), .IDX_W(8)) u_dut (
      .clk(clk), .rst(rst), .restart(restart),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .mag_inp(mag_inp), .mag_val(mag_val), .mag_res(mag_res),
      .exp_addr(exp_addr), .exp_data(exp_data),
      .done(done), .pass(pass), .len_err(len_err), .mism(mism),
      .fail_idx(fail_idx), .byte_cnt(byte_cnt)
   );

   flag_seq_checker #(.FLAG_LEN(4), .SEL_OFFSET(2), .IDX_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .restart(1'b0),
      .in_valid(in_valid2), .in_data(in_data2), .in_last(1'b0), .in_ready(in_ready2),
      .mag_inp(mag_inp2), .mag_val(mag_val2), .mag_res(mag_res2),
      .exp_addr(exp_addr2), .exp_data(exp_data2),
      .done(done2), .pass(pass2), .len_err(len_err2), .mism(mism2),
      .fail_idx(fail_idx2), .byte_cnt(byte_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one byte for one cycle and check the stage-1 registers
   task automatic send(input logic [7:0] d, input logic last, input int idx);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #1;
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("mag_inp", {24'd0, mag_inp}, {24'd0, d});
      chk("mag_val", {30'd0, mag_val}, 32'(idx % 4));
      chk("exp_addr", {24'd0, exp_addr}, 32'(idx));
   endtask

   // stream n bytes of cand_b, optionally with random idle gaps
   task automatic run_cand(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send(cand_b[i], (i == n - 1), i);
      end
      chk("done_latency0", {31'd0, done}, 32'd0);
      tick();
      chk("done_latency1", {31'd0, done}, 32'd1);
   endtask

   task automatic verdict(input string tag, input bit e_pass, input bit e_mism,
                          input bit e_len, input int e_fidx, input int e_cnt);
      $display("%s: done=%0b pass=%0b mism=%0b len_err=%0b fail_idx=%0d byte_cnt=%0d",
               tag, done, pass, mism, len_err, fail_idx, byte_cnt);
      chk({tag, ".pass"}, {31'd0, pass}, {31'd0, e_pass});
      chk({tag, ".mism"}, {31'd0, mism}, {31'd0, e_mism});
      chk({tag, ".len_err"}, {31'd0, len_err}, {31'd0, e_len});
      chk({tag, ".fail_idx"}, {24'd0, fail_idx}, 32'(e_fidx));
      chk({tag, ".byte_cnt"}, {24'd0, byte_cnt}, 32'(e_cnt));
      chk({tag, ".in_ready_done"}, {31'd0, in_ready}, 32'd0);
      tick();
      chk({tag, ".done_hold"}, {31'd0, done}, 32'd1);
      chk({tag, ".pass_hold"}, {31'd0, pass}, {31'd0, e_pass});
   endtask

   task automatic do_restart();
      restart = 1'b1;
      #1;
      chk("in_ready_restart", {31'd0, in_ready}, 32'd0);
      tick();
      restart = 1'b0;
      #1;
      chk("restart_done", {31'd0, done}, 32'd0);
      chk("restart_cnt", {24'd0, byte_cnt}, 32'd0);
      chk("restart_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic load_good();
      cand_b[0] = 8'h41; cand_b[1] = 8'h43; cand_b[2] = 8'h4E; cand_b[3] = 8'h7B;
      cand_b[4] = 8'h00;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_cnt", {24'd0, byte_cnt}, 32'd0);
      chk("rst_mag_inp", {24'd0, mag_inp}, 32'd0);
      rst = 1'b1;
      tick();
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // correct stream, back-to-back
      load_good();
      run_cand(4, 1'b0);
      verdict("good", 1'b1, 1'b0, 1'b0, 0, 4);
      do_restart();

      // mismatch at index 1
      load_good();
      cand_b[1] = 8'h44;
      run_cand(4, 1'b0);
      verdict("mism1", 1'b0, 1'b1, 1'b0, 1, 4);
      do_restart();

      // too long: 5th byte not compared
      load_good();
      run_cand(5, 1'b0);
      verdict("long5", 1'b0, 1'b0, 1'b1, 0, 5);
      do_restart();

      // too short: 3 bytes
      load_good();
      run_cand(3, 1'b0);
      verdict("short3", 1'b0, 1'b0, 1'b1, 0, 3);
      do_restart();

      // single byte with last
      load_good();
      run_cand(1, 1'b0);
      verdict("single", 1'b0, 1'b0, 1'b1, 0, 1);
      do_restart();

      // restart during the 3rd byte with random gaps, then a correct stream
      load_good();
      for (int i = 0; i < 2; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(cand_b[i], 1'b0, i);
      end
      in_valid = 1'b1;
      in_data  = cand_b[2];
      restart  = 1'b1;
      #1;
      chk("restart_byte_ready", {31'd0, in_ready}, 32'd0);
      tick();
      restart  = 1'b0;
      in_valid = 1'b0;
      chk("restart_byte_cnt", {24'd0, byte_cnt}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("restart_no_done", {31'd0, done}, 32'd0);
      end
      run_cand(4, 1'b1);
      verdict("after_restart", 1'b1, 1'b0, 1'b0, 0, 4);
      do_restart();

      // SEL_OFFSET=2 instance
      in_valid2 = 1'b1;
      in_data2  = 8'h41;
      tick();
      in_valid2 = 1'b0;
      $display("sel_offset2: mag_val=%0d mag_res=%02h", mag_val2, mag_res2);
      chk("off2_mag_val", {30'd0, mag_val2}, 32'd2);
      chk("off2_mag_res", {24'd0, mag_res2}, 32'h8E);
      chk("off2_exp_addr", {24'd0, exp_addr2}, 32'd0);

      // asynchronous reset mid-run
      load_good();
      send(cand_b[0], 1'b0, 0);
      send(cand_b[1], 1'b0, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_cnt", {24'd0, byte_cnt}, 32'd0);
      chk("arst_mag_inp", {24'd0, mag_inp}, 32'd0);
      chk("arst_mag_val", {30'd0, mag_val}, 32'd0);
      chk("arst_exp_addr", {24'd0, exp_addr}, 32'd0);
      chk("arst_flags", {28'd0, done, pass, len_err, mism}, 32'd0);
      chk("arst_fail_idx", {24'd0, fail_idx}, 32'd0);
      tick();
      chk("arst_held", {24'd0, byte_cnt}, 32'd0);
      rst = 1'b1;
      tick();
      chk("arst_no_done", {31'd0, done}, 32'd0);
      run_cand(4, 1'b0);
      verdict("after_arst", 1'b1, 1'b0, 1'b0, 0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_seq_checker.md
Name: flag_seq_checker

Overview:
- Streaming front/back end wrapped around the per-byte transform stage of the flag checker.
- Accepts candidate flag bytes over a valid/ready stream and drives each byte plus a position-derived op select into the transform stage.
- Compares the transform result against an external expected-byte ROM and reports a final pass/fail verdict with first-mismatch index and length error.

Parameters:
FLAG_LEN, 16, number of bytes in the expected flag (legal range 1..255)
SEL_OFFSET, 0, added mod 4 to byte index to form op select
IDX_W, 8, width of index/count fields; must satisfy 2^IDX_W > FLAG_LEN

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
restart  in  1  sync one-cycle pulse: abort/clear, return to IDLE
in_valid  in  1  candidate byte valid
in_data  in  8  candidate byte
in_last  in  1  marks final byte of candidate
in_ready  out  1  byte accepted when in_valid & in_ready
mag_inp  out  8  registered byte to transform stage
mag_val  out  2  registered op select to transform stage
mag_res  in  8  transform result (combinational from mag_inp/mag_val)
exp_addr  out  IDX_W  ROM address (registered byte index)
exp_data  in  8  expected transformed byte (combinational ROM)
done  out  1  verdict valid, held until restart
pass  out  1  1 = exact match of all FLAG_LEN bytes
len_err  out  1  byte count != FLAG_LEN
mism  out  1  at least one compared byte mismatched
fail_idx  out  IDX_W  index of first mismatching byte
byte_cnt  out  IDX_W  bytes accepted this candidate, saturating at 2^IDX_W-1

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, except in_ready, which is combinational and reads 1 in IDLE once rst=1.
- States: IDLE -> RUN on first accepted byte; RUN -> DONE on compare of the in_last byte; DONE -> IDLE on restart. restart in IDLE/RUN -> IDLE.
- in_ready = (state != DONE) & ~restart. restart has priority over a same-cycle in_valid; that byte is not accepted.
- Stage 1 (accept edge): mag_inp <= in_data; mag_val <= (byte_cnt + SEL_OFFSET) mod 4; exp_addr <= byte_cnt; stage-1 valid and last flags are registered; byte_cnt increments (saturating).
- Stage 2 (next edge, stage-1 valid set): compares mag_res against exp_data only when exp_addr < FLAG_LEN; indices >= FLAG_LEN are not compared.
- First mismatch: sets mism and latches fail_idx = exp_addr. Later mismatches do not change fail_idx.
- Back-to-back acceptance at 1 byte/cycle is supported; stages 1 and 2 overlap.
- Completion: when the stage-2 entry carries last, done <= 1 at that edge, i.e. 2 edges after accepting the last byte.
  - len_err <= (byte_cnt != FLAG_LEN).
  - pass <= ~mism_next & ~len_err_next, where mism_next includes this cycle's compare.
- pass, done, len_err, mism and fail_idx are all registered and hold stable in DONE.
- in_last on the first byte is legal: a 1-byte candidate with FLAG_LEN>1 yields len_err=1, pass=0.
- restart: clears byte_cnt, flags and stage-1 valid on the next edge; any in-flight byte is dropped with no verdict.
- Async reset mid-RUN: immediate clear; no partial verdict.
- mag_inp/mag_val keep their last values when idle (no gating required).

Test Plan:
- FLAG_LEN=4, ROM = {0x0A,0x4A,0x9B,0x48}; stream "ACN{" (0x41,0x43,0x4E,0x7B), last on 0x7B, back-to-back -> mag_val sequence 0,1,2,3; done 2 cycles after last accept; pass=1, mism=0, len_err=0, byte_cnt=4.
- Same ROM; stream 0x41,0x44,0x4E,0x7B -> mism=1, fail_idx=1, pass=0, len_err=0.
- Same ROM; stream 0x41,0x43,0x4E,0x7B,0x00 (last on 5th) -> len_err=1, mism=0, pass=0, byte_cnt=5; 3-byte stream with last on 3rd -> len_err=1, pass=0.
- in_valid toggled randomly, with restart during the 3rd byte, then a correct stream -> first candidate yields no done; second gives pass=1; restart-cycle byte not accepted (in_ready=0).
- SEL_OFFSET=2; stream 0x41 at idx0 -> mag_val=2, mag_res expected 0x8E.
- rst driven low mid-RUN asynchronously (between edges) -> all outputs 0 immediately; after release, full correct stream gives pass=1.
